vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator: produces pixel coordinates, visible flag, line/frame start pulses and hsync/vsync for a VGA display pipeline.
- Sits directly upstream of the delay stages. Its hsync/vsync/visible outputs are fed through fixed-latency delay lines so they align with pixel data returned from the framebuffer fetch path.
- All outputs are registered and mutually consistent in every cycle, so a downstream delay of N cycles keeps them aligned.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of hsync (0 = active low)
- V_SYNC_POL, 0, asserted level of vsync (0 = active low)
- COORD_WIDTH, 10, width of x/y outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- inc  input  1  pixel-clock enable; advances the raster one pixel per cycle when high
- x  output  COORD_WIDTH  current column
- y  output  COORD_WIDTH  current row
- visible  output  1  high when (x,y) is in the active area
- line_start  output  1  one-cycle pulse, high when x==0
- frame_start  output  1  one-cycle pulse, high when x==0 && y==0
- hsync  output  1  horizontal sync, level set by H_SYNC_POL
- vsync  output  1  vertical sync, level set by V_SYNC_POL

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- Reset values:
  - Internal started=0; x=0, y=0.
  - visible=0, line_start=0, frame_start=0.
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL (both deasserted).
- Reset asserted mid-frame returns immediately to the reset state. After release the raster restarts at (0,0) as if first powered.
- First inc after reset (started=0):
  - Sets started=1.
  - Next cycle presents (0,0) with visible=1, line_start=1, frame_start=1; syncs deasserted.
- Later inc (started=1):
  - x <= x+1.
  - When x==H_TOTAL-1: x <= 0 and y advances.
  - When y==V_TOTAL-1 at line wrap: y <= 0.
- Latency: every output updates on the clock edge where inc=1. inc=0 holds x, y, visible, hsync, vsync unchanged and forces line_start/frame_start to 0 on that edge.
- line_start and frame_start are high for exactly one cycle per occurrence, regardless of how long inc stays low afterwards.
- Per-axis state machines:
  - Horizontal: H_VIS -> H_FP -> H_SYNC -> H_BP -> H_VIS.
  - Vertical: V_VIS -> V_FP -> V_SYNC -> V_BP -> V_VIS.
  - Horizontal transitions occur on the x boundary (x reaching H_VISIBLE, H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC, and the wrap).
  - Vertical transitions occur only on line wrap, on the corresponding y boundaries.
- Output decode: all outputs are computed from next-state values and registered together, with no combinational path from inc to outputs.
  - visible = (h_state==H_VIS) && (v_state==V_VIS).
  - hsync = H_SYNC_POL while h_state==H_SYNC, else ~H_SYNC_POL.
  - vsync = V_SYNC_POL while v_state==V_SYNC for the whole line (including porch pixels), else ~V_SYNC_POL.
- Simultaneous horizontal wrap and vertical wrap on the same edge: x=0, y=0, both pulses high, states reset to H_VIS/V_VIS.
- Any porch or sync parameter of 0 skips that state; the state machine passes directly to the next state.
- COORD_WIDTH too small for H_TOTAL-1 or V_TOTAL-1 is an elaboration error (assertion).

Test Plan:
All scenarios use the small config H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), unless stated otherwise.
- Reset, then inc=1 continuously:
  - cycle after first inc: x=0, y=0, visible=1, frame_start=1, line_start=1.
  - x=4 gives visible=0.
  - hsync low at x=5,6 and high at x=7.
- Run a full frame (48 incs after the first):
  - y=3 lines are not visible; vsync low for all 8 pixels of y=4.
  - Wrap from (7,5) to (0,0) with frame_start=1 in exactly that cycle.
  - line_start high 6 times per frame, frame_start once.
- Toggle inc 1/0 alternately:
  - Position advances once per inc=1; outputs hold during inc=0.
  - Pulses last 1 cycle even when followed by inc=0.
- Assert reset at (3,2) mid-frame:
  - Outputs go to reset values without waiting for clk.
  - After release plus one inc, (0,0) with frame_start=1.
- Set H_SYNC_POL=1, V_SYNC_POL=1:
  - hsync idles 0 and is 1 at x=5,6.
  - vsync is 1 on y=4.
- Set H_FRONT=0:
  - hsync asserts at x=4 directly after the last visible pixel.
  - H_TOTAL=7, wrap at x=6.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, visible flag, line/frame start pulses and syncs.
// Every output is registered from next-state values, so all of them stay aligned through any fixed delay.
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit H_SYNC_POL  = 1'b0,
    parameter bit V_SYNC_POL  = 1'b0,
    parameter int COORD_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc,
    output logic [COORD_WIDTH-1:0] x,
    output logic [COORD_WIDTH-1:0] y,
    output logic                   visible,
    output logic                   line_start,
    output logic                   frame_start,
    output logic                   hsync,
    output logic                   vsync
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL - 1 >= 2 ** COORD_WIDTH) begin : g_h_width_check
        $error("COORD_WIDTH too small for H_TOTAL-1");
    end
    if (V_TOTAL - 1 >= 2 ** COORD_WIDTH) begin : g_v_width_check
        $error("COORD_WIDTH too small for V_TOTAL-1");
    end

    localparam logic [COORD_WIDTH-1:0] H_LAST = COORD_WIDTH'(H_TOTAL - 1);
    localparam logic [COORD_WIDTH-1:0] V_LAST = COORD_WIDTH'(V_TOTAL - 1);

    // Start coordinate of each region; a zero-length region shares its start with the next one.
    localparam logic [31:0] H_FP_AT   = 32'(H_VISIBLE);
    localparam logic [31:0] H_SYNC_AT = 32'(H_VISIBLE + H_FRONT);
    localparam logic [31:0] H_BP_AT   = 32'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [31:0] V_FP_AT   = 32'(V_VISIBLE);
    localparam logic [31:0] V_SYNC_AT = 32'(V_VISIBLE + V_FRONT);
    localparam logic [31:0] V_BP_AT   = 32'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {ST_H_VIS, ST_H_FP, ST_H_SYNC, ST_H_BP} h_state_t;
    typedef enum logic [1:0] {ST_V_VIS, ST_V_FP, ST_V_SYNC, ST_V_BP} v_state_t;

    h_state_t               h_state, h_next;
    v_state_t               v_state, v_next;
    logic                   started;
    logic [COORD_WIDTH-1:0] x_next, y_next;
    logic                   visible_next, hsync_next, vsync_next;
    logic                   line_start_next, frame_start_next;

    function automatic h_state_t h_decode(input logic [COORD_WIDTH-1:0] c);
        logic [31:0] w;
        w = 32'(c);
        if (w < H_FP_AT)        return ST_H_VIS;
        else if (w < H_SYNC_AT) return ST_H_FP;
        else if (w < H_BP_AT)   return ST_H_SYNC;
        else                    return ST_H_BP;
    endfunction

    function automatic v_state_t v_decode(input logic [COORD_WIDTH-1:0] c);
        logic [31:0] w;
        w = 32'(c);
        if (w < V_FP_AT)        return ST_V_VIS;
        else if (w < V_SYNC_AT) return ST_V_FP;
        else if (w < V_BP_AT)   return ST_V_SYNC;
        else                    return ST_V_BP;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started     <= 1'b0;
            x           <= '0;
            y           <= '0;
            h_state     <= ST_H_VIS;
            v_state     <= ST_V_VIS;
            visible     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
        end else begin
            if (inc) begin
                started <= 1'b1;
            end
            x           <= x_next;
            y           <= y_next;
            h_state     <= h_next;
            v_state     <= v_next;
            visible     <= visible_next;
            line_start  <= line_start_next;
            frame_start <= frame_start_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
        end
    end

    // The first inc after reset only arms the raster and lands on (0,0).
    always_comb begin
        x_next = x;
        y_next = y;
        h_next = h_state;
        v_next = v_state;
        if (inc) begin
            if (!started) begin
                x_next = '0;
                y_next = '0;
            end else if (x == H_LAST) begin
                x_next = '0;
                y_next = (y == V_LAST) ? '0 : y + 1'b1;
            end else begin
                x_next = x + 1'b1;
            end
            h_next = h_decode(x_next);
            v_next = v_decode(y_next);
        end
    end

    always_comb begin
        visible_next     = visible;
        hsync_next       = hsync;
        vsync_next       = vsync;
        line_start_next  = 1'b0;
        frame_start_next = 1'b0;
        if (inc) begin
            visible_next     = (h_next == ST_H_VIS) && (v_next == ST_V_VIS);
            hsync_next       = (h_next == ST_H_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_next       = (v_next == ST_V_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            line_start_next  = (x_next == '0);
            frame_start_next = (x_next == '0) && (y_next == '0);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small configurations driven by shared random stimulus,
// expectations from a frame-position model pushed to a queue and popped by an independent monitor.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       vis;
        logic       ls;
        logic       fs;
        logic       hs;
        logic       vs;
    } exp_t;

    // cfg0: base small config, cfg1: inverted sync polarity, cfg2: zero horizontal front porch
    int cfg_hv[3] = '{4, 4, 4};
    int cfg_hf[3] = '{1, 1, 0};
    int cfg_hs[3] = '{2, 2, 2};
    int cfg_hb[3] = '{1, 1, 1};
    int cfg_vv[3] = '{3, 3, 3};
    int cfg_vf[3] = '{1, 1, 1};
    int cfg_vs[3] = '{1, 1, 1};
    int cfg_vb[3] = '{1, 1, 1};
    bit cfg_hp[3] = '{1'b0, 1'b1, 1'b0};
    bit cfg_vp[3] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic reset;
    logic inc;
    logic [9:0] xs[3];
    logic [9:0] ys[3];
    logic vis[3], ls[3], fs[3], hsy[3], vsy[3];
    exp_t [2:0] act;

    exp_t [2:0] sbq[$];
    int  checks = 0;
    int  errors = 0;
    bit  st[3];
    int  pos[3];

    always #5 clk = ~clk;

    vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                     .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COORD_WIDTH(10)) dut0 (
        .clk(clk), .reset(reset), .inc(inc), .x(xs[0]), .y(ys[0]), .visible(vis[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .hsync(hsy[0]), .vsync(vsy[0]));

    vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                     .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COORD_WIDTH(10)) dut1 (
        .clk(clk), .reset(reset), .inc(inc), .x(xs[1]), .y(ys[1]), .visible(vis[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .hsync(hsy[1]), .vsync(vsy[1]));

    vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(0), .H_SYNC(2), .H_BACK(1),
                     .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COORD_WIDTH(10)) dut2 (
        .clk(clk), .reset(reset), .inc(inc), .x(xs[2]), .y(ys[2]), .visible(vis[2]),
        .line_start(ls[2]), .frame_start(fs[2]), .hsync(hsy[2]), .vsync(vsy[2]));

    for (genvar g = 0; g < 3; g++) begin : g_act
        assign act[g] = {xs[g], ys[g], vis[g], ls[g], fs[g], hsy[g], vsy[g]};
    end

    function automatic int h_total(input int c);
        return cfg_hv[c] + cfg_hf[c] + cfg_hs[c] + cfg_hb[c];
    endfunction

    function automatic int v_total(input int c);
        return cfg_vv[c] + cfg_vf[c] + cfg_vs[c] + cfg_vb[c];
    endfunction

    // Outputs as a function of the linear pixel index within the frame.
    function automatic exp_t model_out(input int c, input int p, input bit started, input bit adv);
        exp_t e;
        int   ht, col, row;
        bit   h_in, v_in;
        ht = h_total(c);
        e  = '0;
        if (!started) begin
            e.hs = ~cfg_hp[c];
            e.vs = ~cfg_vp[c];
            return e;
        end
        col  = p % ht;
        row  = p / ht;
        h_in = (col >= cfg_hv[c] + cfg_hf[c]) && (col < cfg_hv[c] + cfg_hf[c] + cfg_hs[c]);
        v_in = (row >= cfg_vv[c] + cfg_vf[c]) && (row < cfg_vv[c] + cfg_vf[c] + cfg_vs[c]);
        e.x   = 10'(col);
        e.y   = 10'(row);
        e.vis = (col < cfg_hv[c]) && (row < cfg_vv[c]);
        e.ls  = adv && (col == 0);
        e.fs  = adv && (p == 0);
        e.hs  = h_in ? cfg_hp[c] : ~cfg_hp[c];
        e.vs  = v_in ? cfg_vp[c] : ~cfg_vp[c];
        return e;
    endfunction

    // Called just after a clock edge: sets inputs for the next edge and queues what should follow it.
    task automatic step(input bit rst_v, input bit inc_v);
        exp_t [2:0] nxt;
        exp_t [2:0] now;
        if (rst_v && !reset) begin
            for (int c = 0; c < 3; c++) now[c] = model_out(c, 0, 1'b0, 1'b0);
            sbq.delete();
            sbq.push_back(now);
        end
        reset = rst_v;
        inc   = inc_v;
        for (int c = 0; c < 3; c++) begin
            if (rst_v) begin
                st[c]  = 1'b0;
                pos[c] = 0;
                nxt[c] = model_out(c, 0, 1'b0, 1'b0);
            end else if (inc_v) begin
                if (!st[c]) begin
                    st[c]  = 1'b1;
                    pos[c] = 0;
                end else begin
                    pos[c] = (pos[c] + 1) % (h_total(c) * v_total(c));
                end
                nxt[c] = model_out(c, pos[c], 1'b1, 1'b1);
            end else begin
                nxt[c] = model_out(c, pos[c], st[c], 1'b0);
            end
        end
        sbq.push_back(nxt);
    endtask

    task automatic cyc(input bit rst_v, input bit inc_v);
        @(posedge clk);
        #1;
        step(rst_v, inc_v);
    endtask

    initial begin : monitor
        exp_t [2:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int c = 0; c < 3; c++) begin
                    checks++;
                    if (act[c] !== e[c]) begin
                        errors++;
                        $display("FAIL cfg%0d t=%0t got x=%0d y=%0d vis=%b ls=%b fs=%b hs=%b vs=%b want x=%0d y=%0d vis=%b ls=%b fs=%b hs=%b vs=%b",
                                 c, $time, act[c].x, act[c].y, act[c].vis, act[c].ls, act[c].fs, act[c].hs, act[c].vs,
                                 e[c].x, e[c].y, e[c].vis, e[c].ls, e[c].fs, e[c].hs, e[c].vs);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int  budget;
        exp_t [2:0] r;
        reset = 1'b1;
        inc   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            st[c]  = 1'b0;
            pos[c] = 0;
            r[c]   = model_out(c, 0, 1'b0, 1'b0);
        end
        sbq.push_back(r);

        repeat (2) cyc(1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0);
        repeat (60) cyc(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cyc(1'b0, i[0] == 1'b0);
        cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);

        // Walk to (3,2) of the base config, then reset between clock edges.
        budget = 0;
        while (!(st[0] && pos[0] == 19) && budget < 400) begin
            cyc(1'b0, 1'($urandom_range(0, 1)));
            budget++;
        end
        checks++;
        if (!(st[0] && pos[0] == 19)) begin
            errors++;
            $display("FAIL reach_mid_frame got pos=%0d want pos=19", pos[0]);
        end
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0);
        end
        cyc(1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
